// File: rtl/rr_scan_mux.sv
// Registered N_CH:1 channel mux with manual or round-robin select and a valid/ready output register.
// Optional RR_SCAN_MUX_PARITY_EN adds out_par, the XOR-reduce of the loaded word.
module rr_scan_mux #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ack,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err
`ifdef RR_SCAN_MUX_PARITY_EN
  ,
  output logic              out_par
`endif
);

  // Per-channel views are padded to a power of two so any sel_in value indexes safely.
  localparam int N_PAD = 1 << SEL_W;

  logic [N_PAD-1:0] cand;
  logic [W-1:0]     ch_data [N_PAD];
  logic             load, sel_oor, gnt_vld, auto_hit;
  logic [SEL_W-1:0] gnt, auto_g, last_ch, idx;

  genvar k;
  generate
    for (k = 0; k < N_PAD; k++) begin : g_ch
      if (k < N_CH) begin : g_real
        assign ch_data[k] = in_data[k*W +: W];
      end else begin : g_pad
        assign ch_data[k] = '0;
      end
    end
  endgenerate

  assign cand    = N_PAD'(in_valid & ch_mask);
  assign load    = !out_valid || out_ready;
  assign sel_oor = int'(sel_in) >= N_CH;

  // Rotating search from last_ch+1; walking the distance downward leaves the nearest hit.
  always_comb begin
    auto_hit = 1'b0;
    auto_g   = '0;
    idx      = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = SEL_W'((int'(last_ch) + i) % N_CH);
      if (cand[idx]) begin
        auto_hit = 1'b1;
        auto_g   = idx;
      end
    end
  end

  assign gnt_vld = mode ? auto_hit : (!sel_oor && cand[sel_in]);
  assign gnt     = mode ? auto_g : sel_in;

  generate
    for (k = 0; k < N_CH; k++) begin : g_ack
      assign in_ack[k] = rst_n && load && gnt_vld && (gnt == SEL_W'(k));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last_ch   <= SEL_W'(N_CH - 1);
      sel_err   <= 1'b0;
`ifdef RR_SCAN_MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      sel_err <= load && !mode && sel_oor;
      if (load) begin
        out_valid <= gnt_vld;
        if (gnt_vld) begin
          out_data <= ch_data[gnt];
          out_ch   <= gnt;
          last_ch  <= gnt;
`ifdef RR_SCAN_MUX_PARITY_EN
          out_par  <= ^ch_data[gnt];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_scan_mux.sv
// Bench for rr_scan_mux (N_CH=6, W=4): directed scenarios pinned by literals plus random traffic
// compared every cycle against a transaction-level model of the output register.
module tb_rr_scan_mux;
  localparam int N  = 6;
  localparam int W  = 4;
  localparam int SW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid, in_ack, ch_mask;
  logic            mode, out_valid, out_ready, sel_err;
  logic [SW-1:0]   sel_in, out_ch;
  logic [W-1:0]    out_data;
`ifdef RR_SCAN_MUX_PARITY_EN
  logic            out_par;
`endif

  always #5 clk = ~clk;

  rr_scan_mux #(.N_CH(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .ch_mask(ch_mask), .mode(mode), .sel_in(sel_in), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
`ifdef RR_SCAN_MUX_PARITY_EN
    , .out_par(out_par)
`endif
  );

  int n_chk = 0, n_err = 0;
  // Model: contents of the output register, last granted channel, pending select error.
  int m_valid, m_data, m_ch, m_last, m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int din(input int k);
    return int'(in_data[k*W +: W]);
  endfunction

  // Which channel the rules award this cycle, or -1.
  function automatic int model_grant();
    logic [N-1:0] c;
    int g;
    c = in_valid & ch_mask;
    g = -1;
    if (!mode) begin
      if (int'(sel_in) < N && c[sel_in]) g = int'(sel_in);
    end else begin
      for (int d = 1; d <= N; d++)
        if (g < 0 && c[(m_last + d) % N]) g = (m_last + d) % N;
    end
    return g;
  endfunction

  task automatic cyc();
    int g;
    bit ld;
    @(negedge clk);
    ld = (m_valid == 0) || out_ready;
    g  = model_grant();
    chk("out_valid", out_valid, m_valid);
    if (m_valid != 0) begin
      chk("out_data", out_data, m_data);
      chk("out_ch", out_ch, m_ch);
`ifdef RR_SCAN_MUX_PARITY_EN
      chk("out_par", out_par, ^(W'(m_data)));
`endif
    end
    chk("sel_err", sel_err, m_err);
    chk("in_ack", in_ack, (ld && g >= 0) ? (1 << g) : 0);
    @(posedge clk);
    m_err = (!mode && ld && int'(sel_in) >= N) ? 1 : 0;
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1; m_data = din(g); m_ch = g; m_last = g;
      end else m_valid = 0;
    end
    #1;
  endtask

  // Asserts reset between edges so the asynchronous clear is observable before any clock.
  task automatic pulse_rst();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_err", sel_err, 0);
    chk("rst_ack", in_ack, 0);
    m_valid = 0; m_data = 0; m_ch = 0; m_last = N - 1; m_err = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k + 1);
    in_valid = '1; ch_mask = '1; mode = 1'b1; sel_in = '0; out_ready = 1'b1;
    pulse_rst();

    // Auto scan over all channels: 0..5 then wrap to 0.
    for (int i = 0; i <= N; i++) begin
      cyc();
      chk("t1_ch", out_ch, i % N);
      chk("t1_data", out_data, i % N + 1);
    end

    // Masked scan: only channels 2 and 5 eligible.
    ch_mask = 6'b100100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_ch", out_ch, (i % 2) ? 5 : 2);
    end

    // Manual select with backpressure: word held, ack only on the load cycle.
    pulse_rst();
    mode = 1'b0; sel_in = 3'd3; in_valid = 6'b001000; ch_mask = '1; out_ready = 1'b0;
    cyc();
    chk("t3_load", out_valid, 1);
    chk("t3_data", out_data, 4);
    in_data[3*W +: W] = 4'd9;
    repeat (3) begin
      cyc();
      chk("t3_hold", out_data, 4);
      chk("t3_noack", in_ack, 0);
    end
    out_ready = 1'b1;
    cyc();
    chk("t3_next", out_data, 9);

    // Out-of-range manual select.
    sel_in = 3'd7;
    cyc();
    chk("t4_err", sel_err, 1);
    chk("t4_vld", out_valid, 0);
    sel_in = 3'd3;
    cyc();
    chk("t4_err_clr", sel_err, 0);

    // Reset in the middle of a streaming burst.
    mode = 1'b1; in_valid = '1; ch_mask = '1; out_ready = 1'b1;
    repeat (3) cyc();
    pulse_rst();
    cyc();
    chk("t5_first", out_ch, 0);

`ifdef RR_SCAN_MUX_PARITY_EN
    pulse_rst();
    mode = 1'b0; sel_in = 3'd1; in_data[1*W +: W] = 4'b1011;
    cyc();
    chk("t6_par", out_par, 1);
`endif

    // Random traffic.
    repeat (500) begin
      in_data   = (N*W)'($urandom);
      in_valid  = N'($urandom);
      ch_mask   = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
      mode      = 1'($urandom_range(0, 1));
      sel_in    = SW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) pulse_rst();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
